// File: rtl/aes_key_expand.sv
// AES-128 key schedule: expands a cipher key one round key per cycle into an
// encrypt table rk[] and an equivalent-inverse-cipher decrypt table dk[].
// Both tables are read combinationally through a single indexed port.
`timescale 1ns/1ps

module aes_key_expand #(
    parameter int unsigned NR    = 10,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [127:0]     key_in,
    output logic             busy,
    output logic             done,
    output logic             key_valid,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic             rd_dec,
    output logic [127:0]     rd_key
);

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         done_q, done_d;
    logic [127:0] rk_q [0:NR];
    logic [127:0] dk_q [0:NR];

    logic         wr_en;
    logic [3:0]   wr_idx;
    logic [127:0] wr_rk, wr_dk;
    logic [3:0]   prev_idx;
    logic [127:0] prev_key, next_key;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 = prod of a^(2^i), i=1..7 (0 maps to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r, sq;
        r  = 8'h01;
        sq = a;
        for (int unsigned i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // S-box: field inverse followed by the FIPS-197 affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // InvMixColumns over four columns; byte 0 of each column is its MSB
    function automatic logic [127:0] inv_mix(input logic [127:0] w);
        logic [127:0] o;
        logic [31:0]  col;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            col = w[127-32*c -: 32];
            a0  = col[31:24];
            a1  = col[23:16];
            a2  = col[15:8];
            a3  = col[7:0];
            o[127-32*c -: 32] = {
                gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
        end
        return o;
    endfunction

    // One AES-128 expansion step from the previous round key
    always_comb begin
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        prev_idx = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        prev_key = rk_q[prev_idx];
        w0 = prev_key[127:96];
        w1 = prev_key[95:64];
        w2 = prev_key[63:32];
        w3 = prev_key[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rcon(cnt_q), 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    // Next-state, counter and table-write control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = cnt_q;
        wr_rk   = next_key;
        wr_dk   = inv_mix(next_key);
        case (state_q)
            IDLE, READY: begin
                if (start) begin
                    wr_en   = 1'b1;
                    wr_idx  = 4'd0;
                    wr_rk   = key_in;
                    wr_dk   = key_in;
                    cnt_d   = 4'd1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                wr_en = 1'b1;
                if (cnt_q == 4'(NR)) begin
                    wr_dk   = next_key;
                    cnt_d   = 4'd0;
                    done_d  = 1'b1;
                    state_d = READY;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Round-key tables; reset clears any partial expansion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i <= NR; i++) begin
                rk_q[i] <= '0;
                dk_q[i] <= '0;
            end
        end else if (wr_en) begin
            rk_q[wr_idx] <= wr_rk;
            dk_q[wr_idx] <= wr_dk;
        end
    end

    assign busy      = (state_q == EXPAND);
    assign key_valid = (state_q == READY);
    assign done      = done_q;

    // Combinational read port; out-of-range indices read as zero
    always_comb begin
        rd_key = '0;
        if (32'(rd_idx) <= NR) begin
            rd_key = rd_dec ? dk_q[rd_idx] : rk_q[rd_idx];
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: known-answer table, randomized keys
// against a word-level FIPS-197 model, plus start-hold and mid-run reset cases.
`timescale 1ns/1ps

module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         busy, done, key_valid;
    logic [3:0]   rd_idx;
    logic         rd_dec;
    logic [127:0] rd_key;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] m_rk [11];
    logic [127:0] m_dk [11];

    typedef struct {
        string        name;
        logic [127:0] key;
        int unsigned  idx;
        logic         dec;
        logic [127:0] exp;
    } vec_t;

    aes_key_expand #(.NR(10), .IDX_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
        .busy(busy), .done(done), .key_valid(key_valid),
        .rd_idx(rd_idx), .rd_dec(rd_dec), .rd_key(rd_key)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        while (y != 8'h00) begin
            if (y[0]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            logic [7:0] c = 8'h63;
            if (a != 0)
                for (int b = 1; b < 256; b++)
                    if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8]
                       ^ inv[(i+7)%8] ^ c[i];
            sbox_t[a] = s;
        end
    endtask

    function automatic logic [127:0] model_inv_mix(input logic [127:0] x);
        logic [7:0]   s [16];
        logic [7:0]   base [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        logic [127:0] o = '0;
        for (int j = 0; j < 16; j++) s[j] = x[127-8*j -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                logic [7:0] acc = 8'h00;
                for (int k = 0; k < 4; k++) acc ^= gmul(base[(k-r+4)%4], s[4*c+k]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        return o;
    endfunction

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t ^= {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) begin
            m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            m_dk[r] = (r == 0 || r == 10) ? m_rk[r] : model_inv_mix(m_rk[r]);
        end
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int unsigned i, input logic d, output logic [127:0] v);
        rd_idx = 4'(i);
        rd_dec = d;
        #1;
        v = rd_key;
    endtask

    task automatic check_all(input string tag);
        logic [127:0] v;
        for (int unsigned i = 0; i < 16; i++)
            for (int d = 0; d < 2; d++) begin
                rd(i, 1'(d), v);
                if (i > 10) check($sformatf("%s_oob_i%0d_d%0d", tag, i, d), v, '0);
                else check($sformatf("%s_i%0d_d%0d", tag, i, d), v, d ? m_dk[i] : m_rk[i]);
            end
    endtask

    task automatic run_expand(input logic [127:0] k);
        int lat = 1;
        int bad = 0;
        start  = 1'b1;
        key_in = k;
        tick();
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        if (!busy || key_valid || done) bad++;
        while (!done && lat < 30) begin
            tick();
            lat++;
            if (!done && (!busy || key_valid)) bad++;
        end
        check("done_latency", 128'(lat), 128'd11);
        check("busy_window", 128'(bad), '0);
        check("ready_flags", 128'({busy, done, key_valid}), 128'(3'b011));
        tick();
        check("done_pulse", 128'(done), '0);
        model_expand(k);
    endtask

    initial begin
        vec_t         tbl [$];
        logic [127:0] loaded;
        logic [127:0] v, ka, kb;
        int           ndone;

        build_sbox();
        rst_n = 1'b0; start = 1'b0; key_in = '0; rd_idx = '0; rd_dec = 1'b0;
        #12 rst_n = 1'b1;

        for (int c = 0; c < 20; c++) begin
            tick();
            check("idle_flags", 128'({busy, done, key_valid}), '0);
        end
        for (int unsigned i = 0; i < 16; i++)
            for (int d = 0; d < 2; d++) begin
                rd(i, 1'(d), v);
                check($sformatf("reset_table_i%0d_d%0d", i, d), v, '0);
            end

        tbl.push_back('{"fips_rk1", 128'h2b7e151628aed2a6abf7158809cf4f3c, 1, 1'b0,
                        128'ha0fafe1788542cb123a339392a6c7605});
        tbl.push_back('{"fips_rk10", 128'h2b7e151628aed2a6abf7158809cf4f3c, 10, 1'b0,
                        128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
        tbl.push_back('{"fips_rk0", 128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 1'b0,
                        128'h2b7e151628aed2a6abf7158809cf4f3c});
        tbl.push_back('{"c1_rk10", 128'h000102030405060708090a0b0c0d0e0f, 10, 1'b0,
                        128'h13111d7fe3944a17f307a78b4d2b30c5});
        tbl.push_back('{"c1_dk10", 128'h000102030405060708090a0b0c0d0e0f, 10, 1'b1,
                        128'h13111d7fe3944a17f307a78b4d2b30c5});
        tbl.push_back('{"c1_dk0", 128'h000102030405060708090a0b0c0d0e0f, 0, 1'b1,
                        128'h000102030405060708090a0b0c0d0e0f});
        loaded = 'x;
        foreach (tbl[n]) begin
            if (tbl[n].key !== loaded) begin
                run_expand(tbl[n].key);
                loaded = tbl[n].key;
                check_all("kat_model");
            end
            rd(tbl[n].idx, tbl[n].dec, v);
            check(tbl[n].name, v, tbl[n].exp);
        end

        repeat (4) begin
            run_expand({$urandom, $urandom, $urandom, $urandom});
            check_all("rand");
        end

        // start held high through a whole expansion, key_in changed mid-run
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = ~ka;
        start  = 1'b1;
        key_in = ka;
        tick();
        ndone = 0;
        for (int n = 2; n <= 11; n++) begin
            if (n == 4) key_in = kb;
            tick();
            if (done) ndone++;
        end
        start = 1'b0;
        check("hold_done_at_11", 128'(done), 128'd1);
        repeat (3) begin
            tick();
            if (done) ndone++;
        end
        check("hold_done_once", 128'(ndone), 128'd1);
        model_expand(ka);
        check_all("hold_first_key");
        run_expand(kb);
        check_all("hold_next_key");

        // asynchronous reset five cycles into an expansion
        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_flags", 128'({busy, done, key_valid}), '0);
        for (int unsigned i = 0; i < 16; i++)
            for (int d = 0; d < 2; d++) begin
                rd(i, 1'(d), v);
                check($sformatf("midrst_table_i%0d_d%0d", i, d), v, '0);
            end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", 128'({busy, done, key_valid}), '0);
        run_expand({$urandom, $urandom, $urandom, $urandom});
        check_all("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
